// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: turns a requested target value into per-bit J/K excitation for an external JK bank (optional readback check: JK_READBACK_CHECK_EN)
module jk_excitation_driver #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             TargetValid,
  output logic             TargetReady,
  input  logic [WIDTH-1:0] Target,
  input  logic             Mode,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] ModelQ,
  output logic             Busy,
  output logic             Done,
`ifdef JK_READBACK_CHECK_EN
  input  logic [WIDTH-1:0] QFeedback,
`endif
  output logic             Mismatch
);
  typedef enum logic [1:0] {IDLE, STEP, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] model_q, model_d, j_q, j_d, k_q, k_d, tgt_q, tgt_d, nxt;
  logic             mode_q, mode_d, done_q, done_d, accept;
  assign TargetReady = (state_q == IDLE) && !done_q;
  assign accept      = TargetReady && TargetValid;
  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign J           = j_q;
  assign K           = k_q;
  assign ModelQ      = model_q;
  assign nxt         = mode_q ? ((tgt_q > model_q) ? model_q + 1'b1 : model_q - 1'b1) : tgt_q;
  // Next-state: accept in IDLE, walk the model toward the target in STEP, quiesce J/K in DRAIN
  always_comb begin
    state_d = state_q;
    model_d = model_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        tgt_d  = Target;
        mode_d = Mode;
        if (Target == model_q) done_d = 1'b1;
        else state_d = STEP;
      end
      STEP: begin
        j_d     = ~model_q & nxt;
        k_d     = model_q & ~nxt;
        model_d = nxt;
        if (nxt == tgt_q) state_d = DRAIN;
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register; reset drives K all-ones so the external bank clears on the next edge
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= IDLE;
      model_q <= '0;
      tgt_q   <= '0;
      mode_q  <= 1'b0;
      j_q     <= '0;
      k_q     <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      model_q <= model_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end
`ifdef JK_READBACK_CHECK_EN
  logic [WIDTH-1:0] model_dly_q;
  logic             chk_en_q, mismatch_q;
  assign Mismatch = mismatch_q;
  // External Q trails the model by one cycle; compare once the post-reset clear has landed
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      model_dly_q <= '0;
      chk_en_q    <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      model_dly_q <= model_q;
      chk_en_q    <= 1'b1;
      if (accept) mismatch_q <= 1'b0;
      else if (chk_en_q && QFeedback != model_dly_q) mismatch_q <= 1'b1;
    end
  end
`else
  assign Mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver: directed checks of jk_excitation_driver against a behavioural JK bank
module tb_jk_excitation_driver;
  logic       Clock = 1'b0;
  logic       ResetN = 1'b0, TargetValid = 1'b0, Mode = 1'b0;
  logic [3:0] Target = '0;
  logic       TargetReady, Busy, Done, Mismatch;
  logic [3:0] J, K, ModelQ, q;
  int         passed = 0, total = 0;
`ifdef JK_READBACK_CHECK_EN
  logic [3:0] flip = '0;
  logic [3:0] QFeedback;
  assign QFeedback = q ^ flip;
`endif

  always #5 Clock = ~Clock;

  // Behavioural stand-in for the external JK flop bank
  always @(posedge Clock) q <= (J & ~q) | (~K & q);

  jk_excitation_driver #(.WIDTH(4)) dut (
    .Clock(Clock), .ResetN(ResetN), .TargetValid(TargetValid), .TargetReady(TargetReady),
    .Target(Target), .Mode(Mode), .J(J), .K(K), .ModelQ(ModelQ), .Busy(Busy), .Done(Done),
`ifdef JK_READBACK_CHECK_EN
    .QFeedback(QFeedback),
`endif
    .Mismatch(Mismatch)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic accept(input logic [3:0] t, input logic m);
    chk("ready_before_accept", TargetReady, 1);
    Target = t; Mode = m; TargetValid = 1'b1;
    step();
    TargetValid = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_j", J, 4'h0); chk("rst_k", K, 4'hF); chk("rst_model", ModelQ, 0);
    chk("rst_done", Done, 0); chk("rst_busy", Busy, 0); chk("rst_ready", TargetReady, 1);
    chk("rst_mismatch", Mismatch, 0);
    ResetN = 1'b1;
    step();
    chk("post_rst_j", J, 0); chk("post_rst_k", K, 0); chk("post_rst_q", q, 0);
    // jump 0000 -> 1010
    accept(4'hA, 1'b0);
    chk("jmp_busy", Busy, 1); chk("jmp_ready", TargetReady, 0); chk("jmp_done0", Done, 0);
    step();
    chk("jmp_j", J, 4'hA); chk("jmp_k", K, 4'h0); chk("jmp_model", ModelQ, 4'hA);
    chk("jmp_done1", Done, 0);
    step();
    chk("jmp_done", Done, 1); chk("jmp_q", q, 4'hA); chk("jmp_jk_idle", {J, K}, 0);
    chk("jmp_busy_end", Busy, 0); chk("jmp_ready_done", TargetReady, 0);
    step();
    chk("jmp_done_pulse", Done, 0);
    // jump 1010 -> 0011
    accept(4'h3, 1'b0);
    step();
    chk("jmp3_j", J, 4'h1); chk("jmp3_k", K, 4'h8);
    step();
    chk("jmp3_done", Done, 1); chk("jmp3_q", q, 4'h3);
    step();
    // count 0011 -> 0110
    accept(4'h6, 1'b1);
    step();
    chk("cnt_m1", ModelQ, 4'h4); chk("cnt_j1", J, 4'h4); chk("cnt_k1", K, 4'h3);
    step();
    chk("cnt_m2", ModelQ, 4'h5); chk("cnt_j2", J, 4'h1); chk("cnt_k2", K, 4'h0);
    chk("cnt_q2", q, 4'h4);
    step();
    chk("cnt_m3", ModelQ, 4'h6); chk("cnt_j3", J, 4'h2); chk("cnt_k3", K, 4'h1);
    chk("cnt_done3", Done, 0);
    step();
    chk("cnt_done", Done, 1); chk("cnt_q", q, 4'h6);
    step();
    // jump to 1111, then count down to 0000
    accept(4'hF, 1'b0);
    step();
    chk("jmpF_j", J, 4'h9);
    step(); step();
    accept(4'h0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("down_model", ModelQ, 15 - k);
      chk("down_no_toggle", J & K, 0);
      chk("down_done_low", Done, 0);
    end
    step();
    chk("down_done", Done, 1); chk("down_q", q, 0); chk("down_model_end", ModelQ, 0);
    step();
    // target equal to ModelQ
    accept(4'h0, 1'b0);
    chk("eq_done", Done, 1); chk("eq_busy", Busy, 0);
    step();
    chk("eq_done_pulse", Done, 0); chk("eq_busy2", Busy, 0);
    // reset mid-count at ModelQ=0101
    accept(4'hF, 1'b1);
    for (int k = 0; k < 5; k++) step();
    chk("mid_model", ModelQ, 4'h5);
    ResetN = 1'b0;
    step();
    chk("mid_rst_model", ModelQ, 0); chk("mid_rst_k", K, 4'hF); chk("mid_rst_j", J, 0);
    chk("mid_rst_done", Done, 0); chk("mid_rst_busy", Busy, 0);
    ResetN = 1'b1;
    step();
    chk("mid_rst_q", q, 0); chk("mid_rst_done2", Done, 0);
    step();
    chk("clean_mismatch", Mismatch, 0);
`ifdef JK_READBACK_CHECK_EN
    flip = 4'b0100;
    step();
    flip = 4'b0000;
    chk("mm_set", Mismatch, 1);
    step();
    chk("mm_sticky", Mismatch, 1);
    accept(4'h0, 1'b0);
    chk("mm_clear", Mismatch, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
